// File: rtl/eq_pkg.sv
// Shared types and constants for the three-band EQ biquad cascade.
// Coefficients and samples are signed Q2.14.
package eq_pkg;

    localparam int NUM_STAGES = 3;
    localparam int NUM_TAPS   = 5;
    localparam int COEF_FRAC  = 14;

    typedef logic signed [15:0] coeff_t;
    typedef coeff_t [NUM_TAPS-1:0] stage_coeffs_t;

    typedef enum logic [2:0] {
        B0,
        B1,
        B2,
        A1,
        A2
    } tap_e;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WRITE
    } state_e;

endpackage

// File: rtl/eq_mac_datapath.sv
// Shared 16x16 multiplier, 36-bit add/subtract accumulator and
// floor-shift/saturate stage used by every biquad stage in turn.
module eq_mac_datapath
    import eq_pkg::*;
#(
    parameter int FRAC = COEF_FRAC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               acc_en,
    input  logic               negate,
    input  coeff_t             coef,
    input  logic signed [15:0] operand,
    output logic signed [15:0] y_sat,
    output logic               sat
);

    logic signed [31:0] prod;
    logic signed [35:0] prod_ext;
    logic signed [35:0] acc;
    logic signed [35:0] acc_shift;

    assign prod      = coef * operand;
    assign prod_ext  = {{4{prod[31]}}, prod};
    assign acc_shift = acc >>> FRAC;

    // Accumulate one Q4.28 product per MAC cycle; feedback taps subtract.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= negate ? acc - prod_ext : acc + prod_ext;
        end
    end

    // Clamp the floored stage result into the signed 16-bit range.
    always_comb begin
        sat   = 1'b0;
        y_sat = acc_shift[15:0];
        if (acc_shift > 36'sd32767) begin
            sat   = 1'b1;
            y_sat = 16'sh7fff;
        end else if (acc_shift < -36'sd32768) begin
            sat   = 1'b1;
            y_sat = 16'sh8000;
        end
    end

endmodule

// File: rtl/eq_biquad_scheduler.sv
// Time-multiplexed scheduler running the low/mid/high Direct Form I
// biquads in order on one shared MAC, one cascade pass per frame edge.
module eq_biquad_scheduler
    import eq_pkg::*;
#(
    parameter bit BOTH_EDGES = 1'b1,
    parameter int COEF_FRAC  = eq_pkg::COEF_FRAC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          l_r_clk,
    input  logic signed [15:0]            audio_in,
    input  stage_coeffs_t [NUM_STAGES-1:0] coeffs,
    output logic signed [15:0]            audio_out,
    output logic                          sample_valid,
    output logic                          busy,
    output logic                          mac_active,
    output logic                          sat_flag,
    output logic                          overrun
);

    state_e                         state;
    tap_e                           tap;
    logic [1:0]                     stage;
    logic                           lr_q;
    logic                           frame_edge;
    stage_coeffs_t [NUM_STAGES-1:0] shadow;
    logic signed [15:0]             x_in;
    logic signed [15:0]             x1 [NUM_STAGES];
    logic signed [15:0]             x2 [NUM_STAGES];
    logic signed [15:0]             y1 [NUM_STAGES];
    logic signed [15:0]             y2 [NUM_STAGES];
    logic signed [15:0]             x_op;
    logic signed [15:0]             operand;
    logic                           negate;
    logic signed [15:0]             y_sat;
    logic                           sat;
    logic                           acc_clear;
    logic                           acc_en;

    assign frame_edge = (l_r_clk != lr_q) && (BOTH_EDGES || l_r_clk);
    assign acc_clear  = ((state == IDLE) && frame_edge) || (state == WRITE);
    assign acc_en     = (state == MAC);

    // Stage input: captured sample for stage 0, else previous stage's y.
    always_comb begin
        x_op = x_in;
        if (stage == 2'd1) begin
            x_op = y1[0];
        end else if (stage == 2'd2) begin
            x_op = y1[1];
        end
    end

    // Select the MAC operand for the current tap.
    always_comb begin
        operand = x_op;
        negate  = 1'b0;
        unique case (1'b1)
            (tap == B0): operand = x_op;
            (tap == B1): operand = x1[stage];
            (tap == B2): operand = x2[stage];
            (tap == A1): begin
                operand = y1[stage];
                negate  = 1'b1;
            end
            (tap == A2): begin
                operand = y2[stage];
                negate  = 1'b1;
            end
            default: ;
        endcase
    end

    eq_mac_datapath #(
        .FRAC(COEF_FRAC)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (acc_clear),
        .acc_en (acc_en),
        .negate (negate),
        .coef   (shadow[stage][tap]),
        .operand(operand),
        .y_sat  (y_sat),
        .sat    (sat)
    );

    // Frame sequencer: capture, five MACs per stage, history write-back.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            tap          <= B0;
            stage        <= '0;
            lr_q         <= l_r_clk;
            shadow       <= '0;
            x_in         <= '0;
            audio_out    <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            mac_active   <= 1'b0;
            sat_flag     <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
        end else begin
            lr_q         <= l_r_clk;
            sample_valid <= 1'b0;
            if (frame_edge && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (frame_edge) begin
                        x_in       <= audio_in;
                        shadow     <= coeffs;
                        stage      <= '0;
                        tap        <= B0;
                        busy       <= 1'b1;
                        mac_active <= 1'b1;
                        state      <= MAC;
                    end
                end
                MAC: begin
                    if (tap == A2) begin
                        mac_active <= 1'b0;
                        state      <= WRITE;
                    end else begin
                        tap <= tap_e'(tap + 3'd1);
                    end
                end
                WRITE: begin
                    x2[stage] <= x1[stage];
                    x1[stage] <= x_op;
                    y2[stage] <= y1[stage];
                    y1[stage] <= y_sat;
                    if (sat) begin
                        sat_flag <= 1'b1;
                    end
                    if (stage == 2'd2) begin
                        audio_out    <= y_sat;
                        sample_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        stage      <= stage + 2'd1;
                        tap        <= B0;
                        mac_active <= 1'b1;
                        state      <= MAC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_biquad_scheduler.sv
// Scoreboard bench for eq_biquad_scheduler: a reference cascade model
// queues expected outputs per frame, popped when sample_valid fires.
module tb_eq_biquad_scheduler;
    import eq_pkg::*;

    logic                           clk = 1'b0;
    logic                           reset = 1'b0;
    logic                           l_r_clk = 1'b0;
    logic signed [15:0]             audio_in = '0;
    stage_coeffs_t [NUM_STAGES-1:0] coeffs = '0;
    logic signed [15:0]             audio_out;
    logic                           sample_valid;
    logic                           busy;
    logic                           mac_active;
    logic                           sat_flag;
    logic                           overrun;

    int n_chk = 0;
    int n_pass = 0;

    logic signed [15:0] sb [$];
    logic signed [15:0] mx1 [3];
    logic signed [15:0] mx2 [3];
    logic signed [15:0] my1 [3];
    logic signed [15:0] my2 [3];

    int                 lat;
    int                 pulses;
    int                 busy_cnt;
    int                 mac_cnt;
    logic signed [15:0] val;
    logic signed [15:0] expv;
    logic signed [15:0] mout;

    eq_biquad_scheduler #(
        .BOTH_EDGES(1'b1),
        .COEF_FRAC (14)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .l_r_clk     (l_r_clk),
        .audio_in    (audio_in),
        .coeffs      (coeffs),
        .audio_out   (audio_out),
        .sample_valid(sample_valid),
        .busy        (busy),
        .mac_active  (mac_active),
        .sat_flag    (sat_flag),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin
            mx1[s] = '0;
            mx2[s] = '0;
            my1[s] = '0;
            my2[s] = '0;
        end
    endtask

    task automatic model_frame(input logic signed [15:0] xin,
                               output logic signed [15:0] yout);
        longint             acc;
        longint             y;
        logic signed [15:0] x;
        logic signed [15:0] ys;
        x = xin;
        for (int s = 0; s < 3; s++) begin
            acc = longint'(coeffs[s][0]) * x
                + longint'(coeffs[s][1]) * mx1[s]
                + longint'(coeffs[s][2]) * mx2[s]
                - longint'(coeffs[s][3]) * my1[s]
                - longint'(coeffs[s][4]) * my2[s];
            y = acc >>> 14;
            if (y > 32767) y = 32767;
            else if (y < -32768) y = -32768;
            ys = y[15:0];
            mx2[s] = mx1[s];
            mx1[s] = x;
            my2[s] = my1[s];
            my1[s] = ys;
            x = ys;
        end
        yout = x;
    endtask

    task automatic set_pass();
        coeffs = '0;
        for (int s = 0; s < 3; s++) coeffs[s][0] = 16'sh4000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_clear();
        sb.delete();
    endtask

    task automatic pop_exp(output logic signed [15:0] e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = 'x;
    endtask

    // One frame edge, then 30 observed cycles; k = 0 is just after E.
    task automatic run_frame(input logic signed [15:0] x,
                             input int toggle_at,
                             input int chg_at,
                             input int rst_at,
                             input stage_coeffs_t [NUM_STAGES-1:0] newc);
        @(negedge clk);
        audio_in = x;
        l_r_clk  = ~l_r_clk;
        lat      = -1;
        pulses   = 0;
        busy_cnt = 0;
        mac_cnt  = 0;
        val      = 'x;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (sample_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    val = audio_out;
                end
            end
            if (busy) busy_cnt++;
            if (mac_active) mac_cnt++;
            if (k == toggle_at - 1) l_r_clk = ~l_r_clk;
            if (k == chg_at - 1) coeffs = newc;
            if (rst_at > 0 && k == rst_at - 1) reset = 1'b0;
            if (rst_at > 0 && k == rst_at + 1) reset = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        l_r_clk  = 1'b1;
        audio_in = 16'sh1234;
        coeffs   = '0;
        repeat (4) @(negedge clk);
        n_chk++;
        if ({audio_out, sample_valid, busy, mac_active, sat_flag, overrun} !== 21'd0)
            $display("FAIL reset_state got out=%0d sv=%0b busy=%0b mac=%0b sat=%0b ovr=%0b want all 0",
                     audio_out, sample_valid, busy, mac_active, sat_flag, overrun);
        else n_pass++;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++;
        if ({busy, mac_active, audio_out} !== 18'd0)
            $display("FAIL reset_release got busy=%0b mac=%0b out=%0d want 0 0 0",
                     busy, mac_active, audio_out);
        else n_pass++;
    endtask

    task automatic test_passthrough();
        set_pass();
        model_frame(16'sd8192, mout);
        sb.push_back(16'sd8192);
        run_frame(16'sd8192, -1, -1, -1, coeffs);
        pop_exp(expv);
        n_chk++;
        if (val !== expv) $display("FAIL pass_value got %0d want %0d", val, expv);
        else n_pass++;
        n_chk++;
        if (lat !== 18) $display("FAIL pass_latency got %0d want 18", lat);
        else n_pass++;
        n_chk++;
        if (pulses !== 1) $display("FAIL pass_pulses got %0d want 1", pulses);
        else n_pass++;
        n_chk++;
        if (busy_cnt !== 18) $display("FAIL pass_busy_cycles got %0d want 18", busy_cnt);
        else n_pass++;
        n_chk++;
        if (mac_cnt !== 15) $display("FAIL pass_mac_cycles got %0d want 15", mac_cnt);
        else n_pass++;
        n_chk++;
        if (sat_flag !== 1'b0) $display("FAIL pass_sat got %0b want 0", sat_flag);
        else n_pass++;
    endtask

    task automatic test_recursive();
        logic signed [15:0] xs [4];
        logic signed [15:0] ys [4];
        xs = '{16'sd8192, 16'sd0, 16'sd0, 16'sd0};
        ys = '{16'sd8192, 16'sd4096, 16'sd2048, 16'sd1024};
        do_reset();
        set_pass();
        coeffs[0][3] = 16'shE000;
        for (int i = 0; i < 4; i++) begin
            model_frame(xs[i], mout);
            sb.push_back(ys[i]);
            run_frame(xs[i], -1, -1, -1, coeffs);
            pop_exp(expv);
            n_chk++;
            if (val !== expv)
                $display("FAIL recursive_%0d got %0d want %0d", i, val, expv);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        coeffs = '0;
        for (int s = 0; s < 3; s++) coeffs[s][0] = 16'sh7fff;
        model_frame(16'sh4000, mout);
        sb.push_back(16'sd32767);
        run_frame(16'sh4000, -1, -1, -1, coeffs);
        pop_exp(expv);
        n_chk++;
        if (val !== expv) $display("FAIL sat_value got %0d want %0d", val, expv);
        else n_pass++;
        n_chk++;
        if (sat_flag !== 1'b1) $display("FAIL sat_flag got %0b want 1", sat_flag);
        else n_pass++;
        set_pass();
        model_frame(16'sd100, mout);
        sb.push_back(16'sd100);
        run_frame(16'sd100, -1, -1, -1, coeffs);
        pop_exp(expv);
        n_chk++;
        if (val !== expv) $display("FAIL sat_after_value got %0d want %0d", val, expv);
        else n_pass++;
        n_chk++;
        if (sat_flag !== 1'b1) $display("FAIL sat_sticky got %0b want 1", sat_flag);
        else n_pass++;
    endtask

    task automatic test_overrun();
        do_reset();
        n_chk++;
        if (sat_flag !== 1'b0) $display("FAIL sat_cleared got %0b want 0", sat_flag);
        else n_pass++;
        set_pass();
        model_frame(-16'sd5000, mout);
        sb.push_back(mout);
        run_frame(-16'sd5000, 10, -1, -1, coeffs);
        pop_exp(expv);
        n_chk++;
        if (val !== expv) $display("FAIL ovr_value got %0d want %0d", val, expv);
        else n_pass++;
        n_chk++;
        if (pulses !== 1 || lat !== 18)
            $display("FAIL ovr_pulse got pulses=%0d lat=%0d want 1 18", pulses, lat);
        else n_pass++;
        n_chk++;
        if (overrun !== 1'b1) $display("FAIL ovr_flag got %0b want 1", overrun);
        else n_pass++;
    endtask

    task automatic test_tear();
        stage_coeffs_t [NUM_STAGES-1:0] newc;
        set_pass();
        newc = coeffs;
        newc[0][0] = 16'sh2000;
        model_frame(16'sd1000, mout);
        sb.push_back(mout);
        run_frame(16'sd1000, -1, 3, -1, newc);
        pop_exp(expv);
        n_chk++;
        if (val !== expv) $display("FAIL tear_old got %0d want %0d", val, expv);
        else n_pass++;
        model_frame(16'sd1000, mout);
        sb.push_back(mout);
        run_frame(16'sd1000, -1, -1, -1, coeffs);
        pop_exp(expv);
        n_chk++;
        if (val !== expv) $display("FAIL tear_new got %0d want %0d", val, expv);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        set_pass();
        coeffs[0][1] = 16'sh4000;
        run_frame(16'sd3000, -1, -1, 8, coeffs);
        n_chk++;
        if (pulses !== 0) $display("FAIL rst_mid_pulses got %0d want 0", pulses);
        else n_pass++;
        n_chk++;
        if ({audio_out, busy, sat_flag, overrun} !== 19'd0)
            $display("FAIL rst_mid_outputs got out=%0d busy=%0b sat=%0b ovr=%0b want 0",
                     audio_out, busy, sat_flag, overrun);
        else n_pass++;
        model_clear();
        sb.delete();
        model_frame(-16'sd1234, mout);
        sb.push_back(-16'sd1234);
        run_frame(-16'sd1234, -1, -1, -1, coeffs);
        pop_exp(expv);
        n_chk++;
        if (val !== expv) $display("FAIL rst_mid_after got %0d want %0d", val, expv);
        else n_pass++;
    endtask

    task automatic test_random();
        logic signed [15:0] x;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            for (int t = 0; t < 5; t++) begin
                coeffs[s][t] = coeff_t'(int'($urandom_range(6000)) - 3000);
            end
            coeffs[s][0] = coeff_t'(int'($urandom_range(8000)) + 8000);
        end
        for (int i = 0; i < 10; i++) begin
            x = 16'(int'($urandom_range(40000)) - 20000);
            model_frame(x, mout);
            sb.push_back(mout);
            run_frame(x, -1, -1, -1, coeffs);
            pop_exp(expv);
            n_chk++;
            if (val !== expv)
                $display("FAIL random_%0d in=%0d got %0d want %0d", i, x, val, expv);
            else n_pass++;
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_passthrough();
        test_recursive();
        test_saturation();
        test_overrun();
        test_tear();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eq_biquad_scheduler.md
# eq_biquad_scheduler

Time-multiplexed controller and datapath for the three-band EQ cascade. It runs the low, mid and high biquad stages in order on one shared 16×16 signed multiplier and 36-bit accumulator. Each l_r_clk edge starts one sample frame. The block sits between the I2S receive sample and the transmit path, and takes its coefficients from the coefficient register bank.

## Interface
- BOTH_EDGES, 1: 1 = every l_r_clk edge starts a frame; 0 = rising edges only.
- COEF_FRAC, 14: fractional bits of coefficients and samples (Q2.14).
- clk  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-low.
- l_r_clk  input  1  frame clock, synchronous to clk.
- audio_in  input  16  signed Q2.14 input sample.
- coeffs  input  3x5x16  signed Q2.14, indexed [stage][tap]; stage 0 = low, 1 = mid, 2 = high; tap order b0, b1, b2, a1, a2.
- audio_out  output  16  signed cascade output; held between frames.
- sample_valid  output  1  one-cycle pulse when audio_out updates.
- busy  output  1  frame in progress.
- mac_active  output  1  high during MAC cycles.
- sat_flag  output  1  sticky; set when any stage output saturates.
- overrun  output  1  sticky; set when a frame edge arrives while busy.

## Operation
- Each stage is Direct Form I: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
  - The a-terms are subtracted: the product is negated before it is accumulated.
- Per-stage history registers x1, x2, y1, y2 (3×4×16 bits).
- The input of stage s is the saturated output of stage s−1; stage 0 takes the captured audio_in.
- Edge detect: lr_q holds the registered l_r_clk. A frame edge is l_r_clk != lr_q, qualified by BOTH_EDGES.
- FSM states:
  - IDLE: on a frame edge, capture audio_in, load the coefficient shadow register from coeffs, clear acc, set stage=0 and tap=0, go to MAC.
  - MAC: each cycle, acc <= acc ± coef[stage][tap]·operand[tap] and tap++. After tap 4 go to WRITE.
  - WRITE: form the stage output, shift history (x2<=x1, x1<=x, y2<=y1, y1<=y). If stage==2, update audio_out, pulse sample_valid and go to IDLE. Otherwise stage++, tap=0, clear acc and go to MAC.
- Arithmetic:
  - Products are 32-bit Q4.28; the accumulator is 36-bit signed.
  - Stage output = acc >>> COEF_FRAC (arithmetic shift, floor), then saturated to [−32768, 32767].
  - On saturation, set sat_flag. History always stores the saturated value.
- Coefficients are used only from the shadow register. Changes to coeffs during a frame take effect at the next frame.
- A frame edge while busy is ignored and sets overrun; the current frame is not disturbed.
- sat_flag and overrun clear only on reset.

## Timing
- Let E be the clk edge at which IDLE detects a frame edge.
  - MAC at E+1..E+5, WRITE at E+6 (stage 0).
  - MAC at E+7..E+11, WRITE at E+12 (stage 1).
  - MAC at E+13..E+17, WRITE at E+18 (stage 2).
- audio_out changes at E+18. sample_valid is high for exactly the cycle after E+18.
- busy is high from after E through E+18, then low. mac_active is high only in MAC cycles.
- Minimum spacing between frame edges is 19 clk cycles; nominal spacing is about 521.
- Reset values:
  - state IDLE; audio_out, all history, acc, stage and tap = 0.
  - sample_valid, busy, mac_active, sat_flag, overrun = 0.
  - lr_q loads l_r_clk during reset, so no spurious frame on reset release.
- Reset asserted mid-frame aborts the frame at that edge. No sample_valid pulse is produced and all history is cleared.

## Structure
- Package eq_pkg holds:
  - NUM_STAGES=3, NUM_TAPS=5, COEF_FRAC=14.
  - typedef coeff_t (signed 16), typedef stage_coeffs_t (coeff_t [5]).
  - enum tap_e (B0, B1, B2, A1, A2).
  - enum state_e (IDLE, MAC, WRITE).
- Sub-module eq_mac_datapath holds the multiplier, the add/subtract accumulator and the shift/saturate stage. The scheduler holds the FSM, the shadow register, the history registers and the operand mux.

## Test plan
- Passthrough: all stages b0=0x4000, other taps 0; audio_in=8192 on one edge -> audio_out=8192 at E+18, sample_valid high exactly 1 cycle, sat_flag=0.
- Recursive impulse:
  - Stage 0: b0=0x4000, a1=0xE000 (−0.5); stages 1–2 passthrough.
  - Drive impulse 8192, then zeros.
  - Required outputs: 8192, 4096, 2048, 1024 on successive frames.
- Saturation: all b0=0x7FFF, other taps 0; audio_in=0x4000 -> stage 0 = 32767, stage 1 saturates, audio_out=32767, sat_flag=1 and stays set.
- Overrun: second l_r_clk edge at E+10 -> overrun=1, exactly one sample_valid pulse, output unaffected.
- Coefficient tear: change coeffs at E+3 -> the frame uses the old values; the next frame uses the new values.
- Reset mid-frame: assert reset at E+8 -> no sample_valid; all outputs 0. A passthrough frame after release then yields exact passthrough with zero history.
